// File: rtl/dso100fb_pkg.sv
// Shared definitions for the DSO100 framebuffer interrupt controller.
// Optional holdoff build switch: DSO100FB_INTR_HOLDOFF_EN.
package dso100fb_pkg;

   localparam int NEVT_DEFAULT = 4;

   // Bit positions of the framebuffer event sources within evt_in/status/enable.
   typedef enum int unsigned {
      EVT_VSYNC      = 0,
      EVT_FRAME_DONE = 1,
      EVT_UNDERRUN   = 2,
      EVT_DMA_ERROR  = 3
   } evt_idx_e;

endpackage

// File: rtl/dso100fb_intr_holdoff.sv
// Interrupt holdoff down-counter; only built when DSO100FB_INTR_HOLDOFF_EN is defined.
// 'active' reports the counter's next value so the interrupt flop is masked in step with it.
module dso100fb_intr_holdoff #(
   parameter int HOLDOFF_CYCLES = 256
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic load,
   input  logic clear,
   output logic active
);

   localparam logic [15:0] HOLDOFF_LOAD = 16'(HOLDOFF_CYCLES);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // A new acknowledge restarts the window rather than extending it.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = HOLDOFF_LOAD;
      end else if (clear) begin
         cnt_d = '0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign active = (cnt_d != '0);

endmodule

// File: rtl/dso100fb_intr_ctrl.sv
// DSO100 framebuffer interrupt controller: edge-detected sticky status, enable mask, registered IRQ.
// Define DSO100FB_INTR_HOLDOFF_EN to mask the interrupt for HOLDOFF_CYCLES after each acknowledge.
module dso100fb_intr_ctrl
   import dso100fb_pkg::*;
#(
   parameter int NEVT           = NEVT_DEFAULT,
   parameter int HOLDOFF_CYCLES = 256
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic [NEVT-1:0] evt_in,
   input  logic            en_wr,
   input  logic [NEVT-1:0] en_wdata,
   input  logic            ack_wr,
   input  logic [NEVT-1:0] ack_wdata,
   output logic [NEVT-1:0] status,
   output logic [NEVT-1:0] enable,
   output logic            DSO100FB_INTR
);

   if ((HOLDOFF_CYCLES < 1) || (HOLDOFF_CYCLES > 65535)) begin : g_bad_holdoff
      $error("HOLDOFF_CYCLES must lie in 1..65535");
   end

   logic [NEVT-1:0] evt_prev_q;
   logic [NEVT-1:0] evt_rise;
   logic [NEVT-1:0] status_q;
   logic [NEVT-1:0] status_d;
   logic [NEVT-1:0] enable_q;
   logic [NEVT-1:0] enable_d;
   logic            intr_q;
   logic            intr_d;
   logic            holdoff_active;

   assign evt_rise = evt_in & ~evt_prev_q;

   // A new edge beats a simultaneous clear so the event is never lost.
   for (genvar gi = 0; gi < NEVT; gi++) begin : g_status_bit
      assign status_d[gi] = evt_rise[gi] | (status_q[gi] & ~(ack_wr & ack_wdata[gi]));
   end

   assign enable_d = en_wr ? en_wdata : enable_q;
   assign intr_d   = (|(status_q & enable_q)) & ~holdoff_active;

`ifdef DSO100FB_INTR_HOLDOFF_EN
   // No synchronous abort source exists here; only reset ends a holdoff early.
   dso100fb_intr_holdoff #(
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
   ) u_holdoff (
      .aclk    (aclk),
      .aresetn (aresetn),
      .load    (ack_wr & (|ack_wdata)),
      .clear   (1'b0),
      .active  (holdoff_active)
   );
`else
   assign holdoff_active = 1'b0;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         evt_prev_q <= '0;
         status_q   <= '0;
         enable_q   <= '0;
         intr_q     <= 1'b0;
      end else begin
         evt_prev_q <= evt_in;
         status_q   <= status_d;
         enable_q   <= enable_d;
         intr_q     <= intr_d;
      end
   end

   assign status        = status_q;
   assign enable        = enable_q;
   assign DSO100FB_INTR = intr_q;

endmodule

// File: tb/tb_dso100fb_intr_ctrl.sv
// Directed, table-driven bench for dso100fb_intr_ctrl (holdoff checks run when DSO100FB_INTR_HOLDOFF_EN is defined).
module tb_dso100fb_intr_ctrl;
   import dso100fb_pkg::*;

   typedef struct {
      logic [3:0] evt;
      logic       enw;
      logic [3:0] enwd;
      logic       ackw;
      logic [3:0] ackwd;
      logic [3:0] exp_status;
      logic [3:0] exp_enable;
      logic       exp_intr;
   } vec_t;

   logic       aclk = 1'b0;
   logic       aresetn;
   logic [3:0] evt_in;
   logic       en_wr;
   logic [3:0] en_wdata;
   logic       ack_wr;
   logic [3:0] ack_wdata;
   logic [3:0] status;
   logic [3:0] enable;
   logic       intr;

   int checks   = 0;
   int failures = 0;

   always #5 aclk = ~aclk;

   dso100fb_intr_ctrl #(
      .NEVT           (4),
      .HOLDOFF_CYCLES (8)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .evt_in        (evt_in),
      .en_wr         (en_wr),
      .en_wdata      (en_wdata),
      .ack_wr        (ack_wr),
      .ack_wdata     (ack_wdata),
      .status        (status),
      .enable        (enable),
      .DSO100FB_INTR (intr)
   );

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
   task automatic step(input logic [3:0] ev, input logic enw, input logic [3:0] enwd,
                       input logic ackw, input logic [3:0] ackwd);
      @(negedge aclk);
      evt_in    = ev;
      en_wr     = enw;
      en_wdata  = enwd;
      ack_wr    = ackw;
      ack_wdata = ackwd;
      @(posedge aclk);
      #1;
   endtask

   vec_t vecs[19];

   initial begin
      logic seen;
      //           evt      enw  enwd     ackw ackwd    status   enable   intr
      vecs[0]  = '{4'b0000, 1'b1, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0};
      vecs[1]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b0};
      vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b1};
      vecs[3]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0110, 4'b0010, 1'b1};
      vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0110, 4'b0010, 1'b1};
      vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0010, 4'b0010, 1'b1};
      vecs[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b1};
      vecs[7]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0110, 4'b0010, 1'b1};
      vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0110, 4'b0010, 1'b1};
      vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0110, 4'b0000, 1'b1};
      vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0110, 4'b0000, 1'b0};
      vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      vecs[12] = '{4'b0000, 1'b1, 4'b1001, 1'b0, 4'b0000, 4'b0000, 4'b1001, 1'b0};
      vecs[13] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b1000, 4'b1001, 1'b0};
      vecs[14] = '{4'b1001, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b1001, 4'b1001, 1'b1};
      vecs[15] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 4'b1000, 4'b0001, 4'b1001, 1'b1};
      vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b1001, 1'b1};
      vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b1001, 1'b1};
      vecs[18] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1001, 1'b0};

      aresetn   = 1'b0;
      evt_in    = '0;
      en_wr     = 1'b0;
      en_wdata  = '0;
      ack_wr    = 1'b0;
      ack_wdata = '0;
      repeat (3) @(posedge aclk);
      #1;
      chk("reset_status", status, 4'b0000);
      chk("reset_enable", enable, 4'b0000);
      chk("reset_intr", {3'b000, intr}, 4'b0000);
      @(negedge aclk);
      aresetn = 1'b1;

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].evt, vecs[i].enw, vecs[i].enwd, vecs[i].ackw, vecs[i].ackwd);
         $display("vec %0d evt=%b en_wr=%b ack_wr=%b ack=%b -> status=%b enable=%b intr=%b",
                  i, vecs[i].evt, vecs[i].enw, vecs[i].ackw, vecs[i].ackwd, status, enable, intr);
         chk($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
         chk($sformatf("vec%0d_enable", i), enable, vecs[i].exp_enable);
`ifndef DSO100FB_INTR_HOLDOFF_EN
         chk($sformatf("vec%0d_intr", i), {3'b000, intr}, {3'b000, vecs[i].exp_intr});
`endif
      end

      // Level held high for 50 cycles: one event only, ack after cycle 5 must stick.
      step(4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000);
      for (int c = 2; c <= 5; c++) step(4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000);
      chk("hold_status_set", {3'b000, status[EVT_VSYNC]}, 4'b0001);
      step(4'b0001, 1'b0, 4'b0000, 1'b1, 4'b0001);
      chk("hold_ack_clear", {3'b000, status[EVT_VSYNC]}, 4'b0000);
      seen = 1'b0;
      for (int c = 7; c <= 50; c++) begin
         step(4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000);
         seen = seen | status[EVT_VSYNC];
      end
      chk("hold_no_reset", {3'b000, seen}, 4'b0000);
      $display("hold sequence done status=%b", status);
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);

`ifdef DSO100FB_INTR_HOLDOFF_EN
      // Ack, then an enabled event one cycle later: IRQ low for 8 cycles, high on the 9th.
      step(4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0000);
      step(4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0001);
      chk("holdoff_c1", {3'b000, intr}, 4'b0000);
      step(4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000);
      chk("holdoff_c2", {3'b000, intr}, 4'b0000);
      chk("holdoff_status", status, 4'b0010);
      for (int c = 3; c <= 8; c++) begin
         step(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
         chk($sformatf("holdoff_c%0d", c), {3'b000, intr}, 4'b0000);
      end
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
      chk("holdoff_release", {3'b000, intr}, 4'b0001);
      $display("holdoff sequence done intr=%b", intr);
      step(4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1111);
`endif

      // Reset asserted mid-operation (mid-holdoff when built) with all status set.
      step(4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0000);
      step(4'b1111, 1'b0, 4'b0000, 1'b1, 4'b1111);
      chk("pre_reset_status", status, 4'b1111);
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
`ifndef DSO100FB_INTR_HOLDOFF_EN
      chk("pre_reset_intr", {3'b000, intr}, 4'b0001);
`endif
      @(negedge aclk);
      #2;
      aresetn = 1'b0;
      #1;
      chk("async_reset_status", status, 4'b0000);
      chk("async_reset_enable", enable, 4'b0000);
      chk("async_reset_intr", {3'b000, intr}, 4'b0000);
      @(negedge aclk);
      #2;
      aresetn = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
         seen = seen | intr | (|status);
      end
      chk("post_reset_quiet", {3'b000, seen}, 4'b0000);
      step(4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000);
      step(4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000);
      chk("post_reset_edge_status", status, 4'b0100);
      chk("post_reset_edge_intr0", {3'b000, intr}, 4'b0000);
      step(4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000);
      chk("post_reset_edge_intr1", {3'b000, intr}, 4'b0001);
      $display("reset sequence done status=%b intr=%b", status, intr);

      // A level already high at reset release is captured as one event.
      @(negedge aclk);
      evt_in  = 4'b1000;
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      chk("level_in_reset_status", status, 4'b0000);
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      chk("level_at_release_status", status, 4'b1000);
      step(4'b1000, 1'b0, 4'b0000, 1'b1, 4'b1000);
      step(4'b1000, 1'b0, 4'b0000, 1'b0, 4'b0000);
      chk("level_at_release_once", status, 4'b0000);
      $display("release sequence done status=%b", status);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
